// File: rtl/twiddle_sequencer.sv
// rtl/twiddle_sequencer.sv - radix-2 DIF stage sequencer: delays data, drives rotator sw/twiddle, flags results
// Define TWIDDLE_QUARTER_ROM_EN to replace the full {cos, sin} table with a quarter-wave cos table.
module twiddle_sequencer #(
    parameter int N_POINTS      = 1024,
    parameter int STAGE         = 0,
    parameter int DATA_WIDTH    = 16,
    parameter int TWIDDLE_POWER = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_first,
    input  logic [DATA_WIDTH-1:0]      din,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       sw,
    output logic [2*TWIDDLE_POWER-1:0] twiddle,
    output logic                       res_valid,
    output logic                       res_last,
    output logic                       err
);

    localparam int P   = TWIDDLE_POWER;
    localparam int NW  = 2 * N_POINTS;
    localparam int JW  = $clog2(NW);
    localparam int KW  = $clog2(N_POINTS / 2);
    localparam int L   = N_POINTS >> STAGE;
    localparam int LW  = $clog2(L);
    localparam int QN  = N_POINTS / 4;
    localparam int SAT = (1 << (P - 1)) - 1;

    // Quantised cos(2*pi*i/N) for 0 <= i <= N/4, by Taylor series so elaboration needs no math library.
    function automatic int cos_q(input int i);
        real x;
        real term;
        real sum;
        int  r;
        x    = 2.0 * 3.141592653589793 * real'(i) / real'(N_POINTS);
        term = 1.0;
        sum  = 1.0;
        for (int t = 1; t <= 20; t++) begin
            term = -term * x * x / real'((2 * t - 1) * (2 * t));
            sum  = sum + term;
        end
        sum = sum * real'(SAT + 1);
        r   = (sum >= 0.0) ? $rtoi(sum + 0.5) : -$rtoi(0.5 - sum);
        if (r > SAT) begin
            r = SAT;
        end else if (r < -SAT) begin
            r = -SAT;
        end
        return r;
    endfunction

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t          r_state, w_state_nxt;
    logic [JW-1:0]   r_j, w_j_nxt, w_idx;
    logic            w_acc, w_err_set;
    logic [LW-1:0]   w_m;
    logic [KW-1:0]   w_k, r_addr;
    logic [2*P-1:0]  w_tw_rom, r_tw;
    logic [DATA_WIDTH-1:0] r_d1, r_d2;
    logic            r_v1, r_odd1, r_first1, r_last1;
    logic            r_sw, r_tail, r_rv, r_rl, r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_j     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_j     <= w_j_nxt;
        end
    end

    // r_j is the index the next word will take while running.
    always_comb begin
        w_state_nxt = r_state;
        w_j_nxt     = r_j;
        w_acc       = 1'b0;
        w_idx       = '0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && in_first) begin
                    w_acc       = 1'b1;
                    w_j_nxt     = JW'(1);
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!in_valid) begin
                    w_err_set   = 1'b1;
                    w_j_nxt     = '0;
                    w_state_nxt = S_IDLE;
                end else if (in_first) begin
                    w_acc     = 1'b1;
                    w_err_set = 1'b1;
                    w_j_nxt   = JW'(1);
                end else begin
                    w_acc = 1'b1;
                    w_idx = r_j;
                    if (r_j == JW'(NW - 1)) begin
                        w_j_nxt     = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_j_nxt = r_j + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Second half of each L-sample block rotates by W_N^((m-L/2)<<STAGE); first half passes with k=0.
    assign w_m = w_idx[LW:1];
    assign w_k = w_m[LW-1] ? (KW'(w_m[LW-2:0]) << STAGE) : '0;

`ifdef TWIDDLE_QUARTER_ROM_EN
    localparam int QW = $clog2(QN + 1);

    logic signed [P-1:0] w_qrom [QN+1];
    logic [KW:0]         w_kx;
    logic                w_hi;
    logic [QW-1:0]       w_ci, w_si;
    logic signed [P-1:0] w_cos, w_sin;

    for (genvar g = 0; g <= QN; g++) begin : g_qrom
        localparam int C = cos_q(g);
        assign w_qrom[g] = P'(C);
    end

    // Second quadrant mirrors about N/4; -sin is cos shifted a quarter turn.
    always_comb begin
        w_kx  = {1'b0, r_addr};
        w_hi  = (w_kx > (KW+1)'(QN));
        w_ci  = QW'(w_hi ? ((KW+1)'(N_POINTS / 2) - w_kx) : w_kx);
        w_si  = QW'(w_hi ? (w_kx - (KW+1)'(QN)) : ((KW+1)'(QN) - w_kx));
        w_cos = w_hi ? -w_qrom[w_ci] : w_qrom[w_ci];
        w_sin = -w_qrom[w_si];
    end

    assign w_tw_rom = {w_cos, w_sin};
`else
    logic [2*P-1:0] w_rom [N_POINTS/2];

    for (genvar g = 0; g < N_POINTS / 2; g++) begin : g_rom
        localparam int C = (g <= QN) ? cos_q(g) : -cos_q(N_POINTS / 2 - g);
        localparam int S = -cos_q((g <= QN) ? (QN - g) : (g - QN));
        assign w_rom[g] = {P'(C), P'(S)};
    end

    assign w_tw_rom = w_rom[r_addr];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d1     <= '0;
            r_v1     <= 1'b0;
            r_odd1   <= 1'b0;
            r_first1 <= 1'b0;
            r_last1  <= 1'b0;
            r_addr   <= '0;
            r_d2     <= '0;
            r_sw     <= 1'b0;
            r_tw     <= '0;
            r_tail   <= 1'b0;
            r_rv     <= 1'b0;
            r_rl     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_d1     <= din;
            r_v1     <= w_acc;
            r_odd1   <= w_idx[0];
            r_first1 <= (w_idx == '0);
            r_last1  <= (w_idx == JW'(NW - 1));
            r_addr   <= w_k;
            r_d2     <= r_d1;
            r_sw     <= r_v1 & r_odd1;
            if (r_v1 && r_odd1) begin
                r_tw <= w_tw_rom;
            end
            // Rotator results lag by one word, so the result window is aligned words 1..2N.
            r_tail   <= r_v1 & r_last1;
            r_rv     <= (r_v1 & ~r_first1) | r_tail;
            r_rl     <= r_tail;
            r_err    <= r_err | w_err_set;
        end
    end

    assign dout      = r_d2;
    assign sw        = r_sw;
    assign twiddle   = r_tw;
    assign res_valid = r_rv;
    assign res_last  = r_rl;
    assign err       = r_err;

endmodule

// File: tb/tb_twiddle_sequencer.sv
// tb/tb_twiddle_sequencer.sv - self-checking bench for twiddle_sequencer (N=16, stages 0 and 1)
module tb_twiddle_sequencer;

    localparam int  N  = 16;
    localparam int  NW = 2 * N;
    localparam int  DW = 16;
    localparam int  TP = 16;
    localparam real PI = 3.141592653589793;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_first = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0]   dout0, dout1;
    logic [2*TP-1:0] tw0, tw1;
    logic sw0, sw1, rv0, rv1, rl0, rl1, er0, er1;

    twiddle_sequencer #(.N_POINTS(N), .STAGE(0), .DATA_WIDTH(DW), .TWIDDLE_POWER(TP)) u_s0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .din(din),
        .dout(dout0), .sw(sw0), .twiddle(tw0), .res_valid(rv0), .res_last(rl0), .err(er0));

    twiddle_sequencer #(.N_POINTS(N), .STAGE(1), .DATA_WIDTH(DW), .TWIDDLE_POWER(TP)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .din(din),
        .dout(dout1), .sw(sw1), .twiddle(tw1), .res_valid(rv1), .res_last(rl1), .err(er1));

    always #5 clk = ~clk;

    typedef struct {
        logic          acc;
        int            idx;
        logic [DW-1:0] d;
    } hrec_t;

    typedef struct {
        int          stage;
        int          w;
        logic [31:0] tw;
        logic        sw;
        logic        rv;
        logic        rl;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    hrec_t h0, h1, h2;
    int    pos = -1;
    logic  m_err = 1'b0;
    logic [31:0] m_tw0 = '0;
    logic [31:0] m_tw1 = '0;

    logic [31:0] c_tw [2][128];
    logic        c_sw [2][128];
    logic        c_rv [2][128];
    logic        c_rl [2][128];

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int qround(input real v);
        real s;
        int  r;
        s = v * 32768.0;
        r = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
        if (r > 32767) r = 32767;
        if (r < -32767) r = -32767;
        return r;
    endfunction

    // W_N^k for sample n of a given stage, straight from the DIF block rule.
    function automatic logic [31:0] tw_ref(input int stage, input int n);
        int  bl, m, k, c, s;
        real a;
        bl = N >> stage;
        m  = n % bl;
        k  = (m < bl / 2) ? 0 : ((m - bl / 2) << stage);
        a  = 2.0 * PI * real'(k) / real'(N);
        c  = qround($cos(a));
        s  = qround(-$sin(a));
        return {c[15:0], s[15:0]};
    endfunction

    task automatic step(input logic v, input logic f, input logic [DW-1:0] d, input logic r);
        hrec_t nr;
        logic  e_sw, e_rv, e_rl;
        in_valid = v;
        in_first = f;
        din      = d;
        rst      = r;
        @(posedge clk);
        if (r) begin
            h0 = '{1'b0, 0, '0};
            h1 = h0;
            h2 = h0;
            pos   = -1;
            m_err = 1'b0;
            m_tw0 = '0;
            m_tw1 = '0;
        end else begin
            nr = '{1'b0, 0, d};
            if (v && f) begin
                if (pos > 0) m_err = 1'b1;
                nr.acc = 1'b1;
                nr.idx = 0;
            end else if (v && pos > 0) begin
                nr.acc = 1'b1;
                nr.idx = pos;
            end else if (!v && pos > 0) begin
                m_err = 1'b1;
                pos   = -1;
            end
            if (nr.acc) pos = (nr.idx == NW - 1) ? -1 : nr.idx + 1;
            if (h0.acc && (h0.idx % 2 == 1)) begin
                m_tw0 = tw_ref(0, h0.idx / 2);
                m_tw1 = tw_ref(1, h0.idx / 2);
            end
            h2 = h1;
            h1 = h0;
            h0 = nr;
        end
        #1;
        e_sw = h1.acc && (h1.idx % 2 == 1);
        e_rl = h2.acc && (h2.idx == NW - 1);
        e_rv = (h1.acc && h1.idx != 0) || e_rl;
        check("dout0", 32'(dout0), 32'(h1.d));
        check("sw0",   32'(sw0),   32'(e_sw));
        check("tw0",   tw0,        m_tw0);
        check("rv0",   32'(rv0),   32'(e_rv));
        check("rl0",   32'(rl0),   32'(e_rl));
        check("err0",  32'(er0),   32'(m_err));
        check("dout1", 32'(dout1), 32'(h1.d));
        check("sw1",   32'(sw1),   32'(e_sw));
        check("tw1",   tw1,        m_tw1);
        check("rv1",   32'(rv1),   32'(e_rv));
        check("rl1",   32'(rl1),   32'(e_rl));
        check("err1",  32'(er1),   32'(m_err));
        if (cyc < 128) begin
            c_tw[0][cyc] = tw0; c_sw[0][cyc] = sw0; c_rv[0][cyc] = rv0; c_rl[0][cyc] = rl0;
            c_tw[1][cyc] = tw1; c_sw[1][cyc] = sw1; c_rv[1][cyc] = rv1; c_rl[1][cyc] = rl1;
        end
        cyc++;
    endtask

    int fs, rvc, rlc, rl_at, run, maxrun, last0, rpos, rr;

    task automatic tally();
        if (rv0) begin
            run++;
            rvc++;
        end else begin
            run = 0;
        end
        if (run > maxrun) maxrun = run;
        if (rl0) begin
            rlc++;
            if (rl_at < 0) rl_at = cyc - 1;
        end
    endtask

    task automatic tally_clear();
        rvc = 0; rlc = 0; rl_at = -1; run = 0; maxrun = 0;
    endtask

    initial begin
        vecs[0]  = '{0,  0, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{0,  1, 32'h7FFF_0000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{0, 17, 32'h7FFF_0000, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{0, 18, 32'h7FFF_0000, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{0, 19, 32'h7642_CF04, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{0, 21, 32'h5A82_A57E, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{0, 25, 32'h0000_8001, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{0, 31, 32'h89BE_CF04, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{0, 32, 32'h89BE_CF04, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{0, 33, 32'h89BE_CF04, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1,  7, 32'h7FFF_0000, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1,  9, 32'h7FFF_0000, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1, 11, 32'h5A82_A57E, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1, 13, 32'h0000_8001, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1, 14, 32'h0000_8001, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1, 32, 32'hA57E_A57E, 1'b0, 1'b1, 1'b1};

        h0 = '{1'b0, 0, '0};
        h1 = h0;
        h2 = h0;

        step(1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1);

        fs = cyc;
        for (int j = 0; j < NW; j++) step(1'b1, j == 0, 16'(j + 16'h100), 1'b0);
        for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("vec%0d_tw", i), c_tw[vecs[i].stage][fs + vecs[i].w + 1], vecs[i].tw);
            check($sformatf("vec%0d_sw", i), 32'(c_sw[vecs[i].stage][fs + vecs[i].w + 1]), 32'(vecs[i].sw));
            check($sformatf("vec%0d_rv", i), 32'(c_rv[vecs[i].stage][fs + vecs[i].w + 1]), 32'(vecs[i].rv));
            check($sformatf("vec%0d_rl", i), 32'(c_rl[vecs[i].stage][fs + vecs[i].w + 1]), 32'(vecs[i].rl));
        end

        tally_clear();
        last0 = -1;
        for (int fr = 0; fr < 2; fr++) begin
            for (int j = 0; j < NW; j++) begin
                step(1'b1, j == 0, 16'($urandom), 1'b0);
                tally();
                if (fr == 0 && j == NW - 1) last0 = cyc - 1;
            end
        end
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            tally();
        end
        check("b2b_rv_count", 32'(rvc), 32'(2 * NW));
        check("b2b_rv_run", 32'(maxrun), 32'(2 * NW));
        check("b2b_rl_count", 32'(rlc), 32'd2);
        check("b2b_rl_delay", 32'(rl_at - last0), 32'd2);

        for (int j = 0; j < 7; j++) step(1'b1, j == 0, 16'($urandom), 1'b0);
        check("gap_err_before", 32'(er0), 32'd0);
        step(1'b0, 1'b0, 16'h5555, 1'b0);
        check("gap_err", 32'(er0), 32'd1);
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            check("gap_rv_low", 32'(rv0), 32'd0);
        end
        tally_clear();
        for (int j = 0; j < NW; j++) begin
            step(1'b1, j == 0, 16'($urandom), 1'b0);
            tally();
        end
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            tally();
        end
        check("gap_next_rl", 32'(rlc), 32'd1);
        check("gap_err_sticky", 32'(er0), 32'd1);

        step(1'b0, 1'b0, 16'h0, 1'b1);
        for (int j = 0; j < 10; j++) step(1'b1, j == 0, 16'($urandom), 1'b0);
        check("restart_err_before", 32'(er1), 32'd0);
        tally_clear();
        for (int j = 0; j < NW; j++) begin
            step(1'b1, j == 0, 16'($urandom), 1'b0);
            tally();
            if (j == 0) check("restart_err", 32'(er1), 32'd1);
        end
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            tally();
        end
        check("restart_rl", 32'(rlc), 32'd1);

        for (int j = 0; j < 20; j++) step(1'b1, j == 0, 16'($urandom), 1'b0);
        step(1'b1, 1'b0, 16'hBEEF, 1'b1);
        check("rst_dout", 32'(dout0), 32'd0);
        check("rst_sw", 32'(sw0), 32'd0);
        check("rst_tw", tw0, 32'd0);
        check("rst_rv", 32'(rv0), 32'd0);
        check("rst_err", 32'(er0), 32'd0);
        tally_clear();
        for (int j = 0; j < 6; j++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            tally();
        end
        check("rst_no_rl", 32'(rlc), 32'd0);
        check("rst_no_rv", 32'(rvc), 32'd0);

        rpos = -1;
        for (int i = 0; i < 2500; i++) begin
            rr = int'($urandom_range(0, 999));
            if (rr < 3) begin
                step(1'(rr & 1), 1'b0, 16'($urandom), 1'b1);
                rpos = -1;
            end else if (rpos < 0) begin
                if (rr < 300) begin
                    step(1'b1, 1'b1, 16'($urandom), 1'b0);
                    rpos = 1;
                end else begin
                    step(1'($urandom_range(0, 1)), 1'b0, 16'($urandom), 1'b0);
                end
            end else if (rr < 20) begin
                step(1'b0, 1'b0, 16'($urandom), 1'b0);
                rpos = -1;
            end else if (rr < 35) begin
                step(1'b1, 1'b1, 16'($urandom), 1'b0);
                rpos = 1;
            end else begin
                step(1'b1, 1'b0, 16'($urandom), 1'b0);
                rpos = (rpos == NW - 1) ? -1 : rpos + 1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
